// File: rtl/ahb_slave_if_param.sv
// AHB slave front end for an APB bridge: slot decode, address/data pipeline,
// transfer handshake FSM with two-cycle ERROR response and error counter.
module ahb_slave_if_param #(
    parameter int unsigned             ADDR_W     = 32,
    parameter int unsigned             DATA_W     = 32,
    parameter int unsigned             NUM_SLV    = 3,
    parameter logic [ADDR_W-1:0]       BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned             SLOT_LOG2  = 26,
    parameter int unsigned             PIPE_DEPTH = 2
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [2:0]        Hsize,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              apb_done,
    output logic              valid,
    output logic [NUM_SLV-1:0] tempselx,
    output logic [NUM_SLV-1:0] tempselx_q,
    output logic [ADDR_W-1:0] Haddr_q,
    output logic [DATA_W-1:0] Hwdata_q,
    output logic              Hwritereg,
    output logic [DATA_W-1:0] Hrdata,
    output logic              Hreadyout,
    output logic [1:0]        Hresp,
    output logic [15:0]       err_count
);

    // End of the mapped window, one bit wider so the top slot cannot wrap.
    localparam logic [ADDR_W:0] MAP_END =
        {1'b0, BASE_ADDR} + ((ADDR_W+1)'(NUM_SLV) << SLOT_LOG2);
    localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        ERR1 = 2'b10,
        ERR2 = 2'b11
    } state_t;

    state_t state, state_nxt;

    logic              active;
    logic              mapped;
    logic              size_ok;
    logic              to_err1;
    logic [ADDR_W-1:0] slot;
    logic [15:0]       err_cnt;

    logic [ADDR_W-1:0]  addr_pipe [PIPE_DEPTH];
    logic [DATA_W-1:0]  data_pipe [PIPE_DEPTH];
    logic [NUM_SLV-1:0] sel_pipe  [PIPE_DEPTH];
    logic               write_reg;

    assign active  = (Htrans == 2'b10) || (Htrans == 2'b11);
    assign mapped  = (Haddr >= BASE_ADDR) && ({1'b0, Haddr} < MAP_END);
    assign size_ok = (Hsize <= SIZE_MAX);
    assign slot    = (Haddr - BASE_ADDR) >> SLOT_LOG2;

    always_comb begin
        tempselx = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            tempselx[i] = !Hreset && mapped && (slot == ADDR_W'(i));
        end
    end

    always_comb begin
        valid = 1'b0;
        if (!Hreset && ((state == IDLE) || (state == ERR2)))
            valid = Hreadyin && active && mapped && size_ok;
    end

    always_comb begin
        to_err1 = 1'b0;
        if ((state == IDLE) || (state == ERR2))
            to_err1 = Hreadyin && active && !(mapped && size_ok);
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Hreadyout = 1'b1;
        Hresp     = 2'b00;
        Hrdata    = '0;
        unique case (state)
            IDLE, ERR2: begin
                if (state == ERR2) Hresp = 2'b01;
                if (valid)        state_nxt = BUSY;
                else if (to_err1) state_nxt = ERR1;
                else              state_nxt = IDLE;
            end
            BUSY: begin
                Hreadyout = apb_done;
                if (apb_done) begin
                    Hrdata    = Prdata;
                    state_nxt = IDLE;
                end
            end
            ERR1: begin
                Hreadyout = 1'b0;
                Hresp     = 2'b01;
                state_nxt = ERR2;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            err_cnt <= '0;
        end else if (to_err1 && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    // All pipelines share the Hreadyin enable so the stages stay aligned.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            write_reg <= 1'b0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                addr_pipe[i] <= '0;
                data_pipe[i] <= '0;
                sel_pipe[i]  <= '0;
            end
        end else if (Hreadyin) begin
            write_reg    <= Hwrite;
            addr_pipe[0] <= Haddr;
            data_pipe[0] <= Hwdata;
            sel_pipe[0]  <= tempselx;
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
                addr_pipe[i] <= addr_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
                sel_pipe[i]  <= sel_pipe[i-1];
            end
        end
    end

    assign Haddr_q    = addr_pipe[PIPE_DEPTH-1];
    assign Hwdata_q   = data_pipe[PIPE_DEPTH-1];
    assign tempselx_q = sel_pipe[PIPE_DEPTH-1];
    assign Hwritereg  = write_reg;
    assign err_count  = err_cnt;

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// Directed bench for ahb_slave_if_param at default parameters.
module tb_ahb_slave_if_param;

    logic        Hclk, Hreset, Hwrite, Hreadyin, apb_done;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize;
    logic [31:0] Haddr, Hwdata, Prdata;
    logic        valid, Hwritereg, Hreadyout;
    logic [2:0]  tempselx, tempselx_q;
    logic [31:0] Haddr_q, Hwdata_q, Hrdata;
    logic [1:0]  Hresp;
    logic [15:0] err_count;

    int tests_run = 0;
    int tests_failed = 0;

    ahb_slave_if_param #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(3),
        .BASE_ADDR(32'h8000_0000), .SLOT_LOG2(26), .PIPE_DEPTH(2)
    ) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Hsize(Hsize), .Haddr(Haddr), .Hwdata(Hwdata),
        .Prdata(Prdata), .apb_done(apb_done), .valid(valid),
        .tempselx(tempselx), .tempselx_q(tempselx_q), .Haddr_q(Haddr_q),
        .Hwdata_q(Hwdata_q), .Hwritereg(Hwritereg), .Hrdata(Hrdata),
        .Hreadyout(Hreadyout), .Hresp(Hresp), .err_count(err_count)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge Hclk);
    endtask

    initial begin
        Hreset = 1'b1; Hwrite = 1'b0; Hreadyin = 1'b1; apb_done = 1'b0;
        Htrans = 2'b00; Hsize = 3'd2; Haddr = '0; Hwdata = '0; Prdata = '0;

        #12;
        check("rst_ready", Hreadyout, 1'b1);
        check("rst_resp", Hresp, 2'b00);
        check("rst_addr_q", Haddr_q, 32'h0);
        check("rst_errcnt", err_count, 16'h0);
        check("rst_valid", valid, 1'b0);
        check("rst_sel", tempselx, 3'b000);

        // Mapped write to slot 1
        tick();
        Hreset = 1'b0;
        Htrans = 2'b10; Hwrite = 1'b1; Haddr = 32'h8400_0010; Hwdata = 32'hDEAD_BEEF;
        #1;
        check("wr_valid", valid, 1'b1);
        check("wr_sel", tempselx, 3'b010);
        check("wr_ready_addr", Hreadyout, 1'b1);
        tick();
        Htrans = 2'b00; Hwrite = 1'b0;
        #1;
        check("wr_wait1", Hreadyout, 1'b0);
        check("wr_resp", Hresp, 2'b00);
        check("wr_hwritereg", Hwritereg, 1'b1);
        check("wr_addr_q_1edge", Haddr_q, 32'h0);
        check("wr_valid_busy", valid, 1'b0);
        tick();
        check("wr_wait2", Hreadyout, 1'b0);
        check("wr_addr_q", Haddr_q, 32'h8400_0010);
        check("wr_data_q", Hwdata_q, 32'hDEAD_BEEF);
        check("wr_sel_q", tempselx_q, 3'b010);
        check("wr_rdata_nodone", Hrdata, 32'h0);
        apb_done = 1'b1; Prdata = 32'h1234_5678;
        #1;
        check("wr_done_ready", Hreadyout, 1'b1);
        check("wr_done_rdata", Hrdata, 32'h1234_5678);
        tick();
        #1;
        check("idle_done_ign_rdata", Hrdata, 32'h0);
        check("idle_done_ign_ready", Hreadyout, 1'b1);
        apb_done = 1'b0;

        // Unmapped address
        Htrans = 2'b10; Haddr = 32'h8C00_0000;
        #1;
        check("um_valid", valid, 1'b0);
        check("um_sel", tempselx, 3'b000);
        tick();
        Htrans = 2'b00;
        #1;
        check("um_err1_ready", Hreadyout, 1'b0);
        check("um_err1_resp", Hresp, 2'b01);
        check("um_errcnt", err_count, 16'd1);
        tick();
        #1;
        check("um_err2_ready", Hreadyout, 1'b1);
        check("um_err2_resp", Hresp, 2'b01);
        tick();
        #1;
        check("um_back_idle", Hresp, 2'b00);

        // Oversized transfer; a legal request during ERR1 must be ignored
        Htrans = 2'b10; Hsize = 3'b011; Haddr = 32'h8000_0000;
        #1;
        check("bs_valid", valid, 1'b0);
        check("bs_sel", tempselx, 3'b001);
        tick();
        Hsize = 3'd2;
        #1;
        check("bs_err1_valid", valid, 1'b0);
        check("bs_err1_ready", Hreadyout, 1'b0);
        check("bs_err1_resp", Hresp, 2'b01);
        tick();
        #1;
        check("bs_err2_ready", Hreadyout, 1'b1);
        check("bs_err2_resp", Hresp, 2'b01);
        check("bs_errcnt", err_count, 16'd2);
        check("bs_err2_valid", valid, 1'b1);
        Htrans = 2'b00;
        tick();
        #1;
        check("bs_back_idle", Hresp, 2'b00);

        // BUSY transfer type and stalled pipeline
        Htrans = 2'b01;
        #1;
        check("ib_valid", valid, 1'b0);
        check("ib_ready", Hreadyout, 1'b1);
        tick();
        check("ib_still_ready", Hreadyout, 1'b1);
        check("ib_resp", Hresp, 2'b00);
        tick();
        check("ib_addr_q", Haddr_q, 32'h8000_0000);
        Hreadyin = 1'b0; Haddr = 32'h8800_0004;
        for (int i = 0; i < 3; i++) tick();
        check("stall_addr_q", Haddr_q, 32'h8000_0000);
        Hreadyin = 1'b1;
        tick(); tick();
        check("resume_addr_q", Haddr_q, 32'h8800_0004);

        // Reset asserted while BUSY
        Htrans = 2'b10; Hwrite = 1'b1; Haddr = 32'h8800_0000;
        #1;
        check("rb_sel", tempselx, 3'b100);
        tick();
        Htrans = 2'b00;
        #1;
        check("rb_busy", Hreadyout, 1'b0);
        #2 Hreset = 1'b1;
        #1;
        check("rb_ready", Hreadyout, 1'b1);
        check("rb_resp", Hresp, 2'b00);
        check("rb_hwritereg", Hwritereg, 1'b0);
        check("rb_errcnt", err_count, 16'h0);
        tick();
        Hreset = 1'b0;
        tick();
        check("rb_after", Hreadyout, 1'b1);

        // Reset asserted in ERR1: no ERROR cycle afterwards
        Htrans = 2'b10; Haddr = 32'h9000_0000;
        tick();
        Htrans = 2'b00;
        #1;
        check("re_err1", Hresp, 2'b01);
        #2 Hreset = 1'b1;
        tick();
        Hreset = 1'b0;
        #1;
        check("re_resp", Hresp, 2'b00);
        tick();
        check("re_after_resp", Hresp, 2'b00);
        check("re_after_ready", Hreadyout, 1'b1);

        // Saturation
        force dut.err_cnt = 16'hFFFF;
        tick();
        release dut.err_cnt;
        Htrans = 2'b10; Haddr = 32'h8C00_0000;
        tick();
        check("sat_err1", err_count, 16'hFFFF);
        tick();
        check("sat_err1_again", err_count, 16'hFFFF);
        Htrans = 2'b00;
        tick();
        tick();
        check("sat_hold", err_count, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
